bram_line_writer: RTL and testbench

Upstream feeder for the 8-row line-buffer BRAM stage of the bilinear scaler.
- Accepts a 32-bit pixel stream with valid/ready handshake.
- Packs 4 pixels into each 128-bit word and issues BRAM write strobes with a 3-bit row slot and an 8-bit word address.
- Tracks how many complete rows are buffered and not yet released by the downstream reader; back-pressures the source when all row slots are occupied.

---
 rtl/bram_line_writer.sv | 105 ++++++++++
 tb/tb_bram_line_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_line_writer.sv
// Packs a 32-bit pixel stream into 128-bit line-buffer words and tracks how many
// complete rows the downstream reader has not yet released.
module bram_line_writer #(
    parameter int H_ACT = 640,
    parameter int ROWS  = 8
) (
    input  logic         clk,
    input  logic         frst,
    input  logic         i_frame_start,
    input  logic [31:0]  i_pix_data,
    input  logic         i_pix_vld,
    output logic         o_pix_rdy,
    input  logic         i_row_free,
    output logic [2:0]   o_bram_wcnt,
    output logic [7:0]   o_bram_waddr,
    output logic [127:0] o_bram_wdata,
    output logic         o_bram_we,
    output logic         o_row_done,
    output logic [2:0]   o_row_idx,
    output logic [3:0]   o_rows_avail,
    output logic         o_err
);

    localparam int         WORDS     = H_ACT / 4;
    localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);
    localparam logic [3:0] FULL      = 4'(ROWS);

    logic [1:0]  lane;
    logic [7:0]  word_idx;
    logic [2:0]  row_slot;
    logic [3:0]  fill;
    logic [95:0] pack;

    logic accept;
    logic word_done;
    logic row_complete;

    assign o_pix_rdy    = (fill != FULL) & ~i_frame_start;
    assign accept       = i_pix_vld & o_pix_rdy;
    assign word_done    = accept & (lane == 2'd3);
    assign row_complete = word_done & (word_idx == LAST_WORD);
    assign o_rows_avail = fill;

    // The fourth pixel bypasses the pack register and goes straight into the word.
    always_ff @(posedge clk or posedge frst) begin
        if (frst) begin
            lane         <= '0;
            word_idx     <= '0;
            row_slot     <= '0;
            fill         <= '0;
            pack         <= '0;
            o_bram_we    <= 1'b0;
            o_bram_wdata <= '0;
            o_bram_waddr <= '0;
            o_bram_wcnt  <= '0;
            o_row_done   <= 1'b0;
            o_row_idx    <= '0;
            o_err        <= 1'b0;
        end else begin
            o_bram_we  <= word_done;
            o_row_done <= row_complete;
            if (word_done) begin
                o_bram_wdata <= {i_pix_data, pack};
                o_bram_waddr <= word_idx;
                o_bram_wcnt  <= row_slot;
            end
            if (row_complete) begin
                o_row_idx <= row_slot;
            end
            if (i_row_free && fill == 4'd0 && !row_complete) begin
                o_err <= 1'b1;
            end

            if (i_frame_start) begin
                lane     <= '0;
                word_idx <= '0;
                row_slot <= '0;
                fill     <= '0;
            end else begin
                if (accept) begin
                    lane <= lane + 2'd1;
                    case (lane)
                        2'd0:    pack[31:0]  <= i_pix_data;
                        2'd1:    pack[63:32] <= i_pix_data;
                        2'd2:    pack[95:64] <= i_pix_data;
                        default: ;
                    endcase
                end
                if (word_done) begin
                    word_idx <= row_complete ? 8'd0 : word_idx + 8'd1;
                end
                if (row_complete) begin
                    row_slot <= row_slot + 3'd1;
                end
                // A completion and a release in the same cycle cancel out.
                case ({row_complete, i_row_free})
                    2'b10:   fill <= fill + 4'd1;
                    2'b01:   if (fill != 4'd0) fill <= fill - 4'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_line_writer.sv
// Randomised bench for bram_line_writer; expected writes come from a pixel-count
// model that derives slot/address from the running pixel index.
module tb_bram_line_writer;

    localparam int H_ACT = 640;
    localparam int WORDS = H_ACT / 4;
    localparam int ROW_PIX = H_ACT;

    logic         clk = 1'b0;
    logic         frst;
    logic         i_frame_start;
    logic [31:0]  i_pix_data;
    logic         i_pix_vld;
    logic         o_pix_rdy;
    logic         i_row_free;
    logic [2:0]   o_bram_wcnt;
    logic [7:0]   o_bram_waddr;
    logic [127:0] o_bram_wdata;
    logic         o_bram_we;
    logic         o_row_done;
    logic [2:0]   o_row_idx;
    logic [3:0]   o_rows_avail;
    logic         o_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]  m_pix[$];
    int           m_count;
    int           m_fill;
    bit           m_err;
    bit           exp_we;
    bit           exp_done;
    logic [127:0] exp_data;
    int           exp_addr;
    int           exp_row;

    bram_line_writer #(.H_ACT(H_ACT), .ROWS(8)) dut (
        .clk           (clk),
        .frst          (frst),
        .i_frame_start (i_frame_start),
        .i_pix_data    (i_pix_data),
        .i_pix_vld     (i_pix_vld),
        .o_pix_rdy     (o_pix_rdy),
        .i_row_free    (i_row_free),
        .o_bram_wcnt   (o_bram_wcnt),
        .o_bram_waddr  (o_bram_waddr),
        .o_bram_wdata  (o_bram_wdata),
        .o_bram_we     (o_bram_we),
        .o_row_done    (o_row_done),
        .o_row_idx     (o_row_idx),
        .o_rows_avail  (o_rows_avail),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pix.delete();
        m_count = 0;
        m_fill  = 0;
        m_err   = 1'b0;
    endtask

    // Called at a falling edge; drives one cycle and checks the resulting outputs.
    task automatic apply_stimulus(input bit fs, input bit vld, input logic [31:0] d, input bit rf);
        bit acc;
        int word_no;
        i_frame_start = fs;
        i_pix_vld     = vld;
        i_pix_data    = d;
        i_row_free    = rf;
        #1;
        check_output("pix_rdy", 128'(o_pix_rdy), 128'((m_fill != 8) && !fs));
        acc      = vld && (m_fill != 8) && !fs;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        if (fs) begin
            m_pix.delete();
            m_count = 0;
            m_fill  = 0;
        end else begin
            if (acc) begin
                m_pix.push_back(d);
                m_count++;
                if (m_pix.size() == 4) begin
                    word_no  = m_count / 4 - 1;
                    exp_we   = 1'b1;
                    exp_data = {m_pix[3], m_pix[2], m_pix[1], m_pix[0]};
                    exp_addr = word_no % WORDS;
                    exp_row  = (word_no / WORDS) % 8;
                    exp_done = (exp_addr == WORDS - 1);
                    m_pix.delete();
                end
            end
            if (rf && !exp_done) begin
                if (m_fill == 0) m_err = 1'b1;
                else m_fill--;
            end else if (exp_done && !rf) begin
                m_fill++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_output("bram_we", 128'(o_bram_we), 128'(exp_we));
        check_output("row_done", 128'(o_row_done), 128'(exp_done));
        if (exp_we) begin
            check_output("wdata", o_bram_wdata, exp_data);
            check_output("waddr", 128'(o_bram_waddr), 128'(exp_addr));
            check_output("wcnt", 128'(o_bram_wcnt), 128'(exp_row));
        end
        if (exp_done) begin
            check_output("row_idx", 128'(o_row_idx), 128'(exp_row));
        end
        check_output("rows_avail", 128'(o_rows_avail), 128'(m_fill));
        check_output("err", 128'(o_err), 128'(m_err));
        i_frame_start = 1'b0;
        i_pix_vld     = 1'b0;
        i_row_free    = 1'b0;
    endtask

    // Pushes n accepted pixels, either sequential values from base or random.
    task automatic stream(input int n, input bit random_vld, input bit seq_vals, input int base);
        int sent;
        int guard;
        bit v;
        logic [31:0] d;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 20 * n + 100) begin
            v = random_vld ? ($urandom_range(0, 1) == 1) : 1'b1;
            d = seq_vals ? 32'(base + sent) : $urandom;
            if (v && m_fill != 8) sent++;
            apply_stimulus(1'b0, v, d, 1'b0);
            guard++;
        end
        check_output("stream_count", 128'(sent), 128'(n));
    endtask

    task automatic check_reset_values();
        check_output("rst_we", 128'(o_bram_we), 128'(0));
        check_output("rst_wcnt", 128'(o_bram_wcnt), 128'(0));
        check_output("rst_waddr", 128'(o_bram_waddr), 128'(0));
        check_output("rst_wdata", o_bram_wdata, 128'(0));
        check_output("rst_row_done", 128'(o_row_done), 128'(0));
        check_output("rst_row_idx", 128'(o_row_idx), 128'(0));
        check_output("rst_rows_avail", 128'(o_rows_avail), 128'(0));
        check_output("rst_err", 128'(o_err), 128'(0));
    endtask

    initial begin
        frst          = 1'b1;
        i_frame_start = 1'b0;
        i_pix_data    = '0;
        i_pix_vld     = 1'b0;
        i_row_free    = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        frst = 1'b0;
        #1;
        check_output("rst_rdy", 128'(o_pix_rdy), 128'(1));
        @(negedge clk);

        $display("[TB] single row");
        stream(4, 1'b0, 1'b1, 0);
        check_output("word0", o_bram_wdata, 128'h00000003_00000002_00000001_00000000);
        check_output("word0_addr", 128'(o_bram_waddr), 128'(0));
        stream(ROW_PIX - 4, 1'b0, 1'b1, 4);
        check_output("row0_done", 128'(o_row_done), 128'(1));
        check_output("row0_idx", 128'(o_row_idx), 128'(0));
        check_output("row0_avail", 128'(o_rows_avail), 128'(1));

        $display("[TB] fill to full");
        stream(7 * ROW_PIX, 1'b0, 1'b0, 0);
        check_output("full_avail", 128'(o_rows_avail), 128'(8));
        check_output("full_rdy", 128'(o_pix_rdy), 128'(0));
        check_output("full_idx", 128'(o_row_idx), 128'(7));
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, $urandom, 1'b0);
        apply_stimulus(1'b0, 1'b1, $urandom, 1'b1);
        check_output("release_avail", 128'(o_rows_avail), 128'(7));
        check_output("release_rdy", 128'(o_pix_rdy), 128'(1));
        stream(4, 1'b0, 1'b0, 0);
        check_output("row9_wcnt", 128'(o_bram_wcnt), 128'(0));
        stream(ROW_PIX - 4, 1'b0, 1'b0, 0);

        $display("[TB] simultaneous release and completion");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        check_output("drain_avail", 128'(o_rows_avail), 128'(3));
        stream(ROW_PIX - 1, 1'b0, 1'b0, 0);
        apply_stimulus(1'b0, 1'b1, $urandom, 1'b1);
        check_output("simul_done", 128'(o_row_done), 128'(1));
        check_output("simul_avail", 128'(o_rows_avail), 128'(3));

        $display("[TB] underflow");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1);
        check_output("uflow_avail", 128'(o_rows_avail), 128'(0));
        check_output("uflow_err", 128'(o_err), 128'(1));
        apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
        check_output("err_sticky", 128'(o_err), 128'(1));

        $display("[TB] frame restart mid-row");
        stream(5 * ROW_PIX + 37 * 4 + 2, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 1'b1, $urandom, 1'b0);
        check_output("restart_no_we", 128'(o_bram_we), 128'(0));
        check_output("restart_avail", 128'(o_rows_avail), 128'(0));
        stream(4, 1'b0, 1'b0, 0);
        check_output("restart_we", 128'(o_bram_we), 128'(1));
        check_output("restart_waddr", 128'(o_bram_waddr), 128'(0));
        check_output("restart_wcnt", 128'(o_bram_wcnt), 128'(0));

        $display("[TB] throttled source");
        apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
        stream(2 * ROW_PIX, 1'b1, 1'b1, 1000);
        check_output("throttle_avail", 128'(o_rows_avail), 128'(2));

        $display("[TB] mid-operation reset");
        stream(4, 1'b0, 1'b0, 0);
        frst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        frst = 1'b0;
        #1;
        check_output("post_rst_rdy", 128'(o_pix_rdy), 128'(1));
        @(negedge clk);
        stream(8, 1'b0, 1'b0, 0);
        check_output("post_rst_waddr", 128'(o_bram_waddr), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
